// File: rtl/scr1_tcm_port_ctrl.sv
// Port-B requester for the TCM: turns core data requests into memory strobes
// and returns lane-aligned responses. Define SCR1_TCM_PORT_RESP_REG_EN for a registered response stage.
module scr1_tcm_port_ctrl #(
  parameter int          SCR1_WIDTH  = 32,
  parameter int unsigned SCR1_SIZE   = 32'h00010000,
  parameter int          SCR1_AWIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  output logic                           req_ack,
  input  logic                           cmd,
  input  logic [1:0]                     width,
  input  logic [SCR1_AWIDTH-1:0]         addr,
  input  logic [SCR1_WIDTH-1:0]          wdata,
  output logic [SCR1_WIDTH-1:0]          rdata,
  output logic [1:0]                     resp,
  output logic                           mem_ren,
  output logic                           mem_wen,
  output logic [3:0]                     mem_be,
  output logic [$clog2(SCR1_SIZE)-3:0]   mem_addr,
  output logic [SCR1_WIDTH-1:0]          mem_wdata,
  input  logic [SCR1_WIDTH-1:0]          mem_rdata
);

  localparam int SW = $clog2(SCR1_SIZE);

  logic                  accept;
  logic                  misaligned;
  logic                  err;
  logic [1:0]            off;

  logic                  s1_valid;
  logic                  s1_cmd;
  logic [1:0]            s1_off;
  logic                  s1_err;
  logic [1:0]            s1_resp;
  logic [SCR1_WIDTH-1:0] s1_rdata;

  logic [1:0]            out_resp;
  logic [SCR1_WIDTH-1:0] out_rdata;

  assign req_ack = ~rst;
  assign accept  = req & ~rst;
  assign off     = addr[1:0];

  always_comb begin
    misaligned = 1'b0;
    case (width)
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err = misaligned | (width == 2'b11) | (addr >= SCR1_AWIDTH'(SCR1_SIZE));

  assign mem_ren   = accept & ~cmd & ~err;
  assign mem_wen   = accept &  cmd & ~err;
  assign mem_addr  = addr[SW-1:2];
  assign mem_wdata = wdata << {off, 3'b000};

  always_comb begin
    case (width)
      2'b00:   mem_be = 4'b0001 << off;
      2'b01:   mem_be = 4'b0011 << off;
      default: mem_be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cmd   <= 1'b0;
      s1_off   <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= req;
      s1_cmd   <= req & cmd;
      s1_off   <= req ? off : 2'b00;
      s1_err   <= req & err;
    end
  end

  always_comb begin
    s1_resp  = 2'b00;
    s1_rdata = '0;
    if (s1_valid) begin
      if (s1_err) begin
        s1_resp = 2'b10;
      end else begin
        s1_resp = 2'b01;
        if (!s1_cmd) s1_rdata = mem_rdata >> {s1_off, 3'b000};
      end
    end
  end

`ifdef SCR1_TCM_PORT_RESP_REG_EN
  logic [1:0]            s2_resp;
  logic [SCR1_WIDTH-1:0] s2_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_resp  <= 2'b00;
      s2_rdata <= '0;
    end else begin
      s2_resp  <= s1_resp;
      s2_rdata <= s1_rdata;
    end
  end

  assign out_resp  = s2_resp;
  assign out_rdata = s2_rdata;
`else
  assign out_resp  = s1_resp;
  assign out_rdata = s1_rdata;
`endif

  // Gated by rst so a response already in flight is dropped in the reset cycle itself.
  assign resp  = rst ? 2'b00 : out_resp;
  assign rdata = rst ? '0    : out_rdata;

endmodule

// File: tb/tb_scr1_tcm_port_ctrl.sv
// Scoreboard bench for scr1_tcm_port_ctrl with a behavioural port-B memory.
// Honours SCR1_TCM_PORT_RESP_REG_EN for the response latency.
module tb_scr1_tcm_port_ctrl;

  localparam int unsigned SIZE = 32'h00010000;
  localparam int          AW   = $clog2(SIZE) - 2;
`ifdef SCR1_TCM_PORT_RESP_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    int          due;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          req   = 1'b0;
  logic          cmd   = 1'b0;
  logic [1:0]    width = 2'b00;
  logic [31:0]   addr  = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic [1:0]    resp;
  logic          req_ack;
  logic          mem_ren;
  logic          mem_wen;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   ram     [0:(1<<AW)-1];
  logic [31:0]   ref_mem [0:(1<<AW)-1];
  exp_t          q[$];
  exp_t          mit;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            done = 1'b0;

  scr1_tcm_port_ctrl #(
    .SCR1_WIDTH (32),
    .SCR1_SIZE  (SIZE),
    .SCR1_AWIDTH(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_ack  (req_ack),
    .cmd      (cmd),
    .width    (width),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .resp     (resp),
    .mem_ren  (mem_ren),
    .mem_wen  (mem_wen),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Port-B memory: byte-enabled write, read data one cycle after mem_ren.
  always @(posedge clk) begin
    if (mem_wen)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic c, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    logic          e;
    logic [1:0]    o;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic [AW-1:0] idx;
    exp_t          it;
    @(posedge clk);
    #1;
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    o   = a[1:0];
    e   = (w == 2'b11) || (w == 2'b01 && a[0]) || (w == 2'b10 && o != 2'b00) || (a >= SIZE);
    case (w)
      2'b00:   be = 4'b0001 << o;
      2'b01:   be = 4'b0011 << o;
      default: be = 4'b1111;
    endcase
    wd  = d << (8 * o);
    idx = a[AW+1:2];
    it.due = cyc + LAT;
    if (e) begin
      it.resp  = 2'b10;
      it.rdata = '0;
    end else if (c) begin
      it.resp  = 2'b01;
      it.rdata = '0;
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      it.resp  = 2'b01;
      it.rdata = ref_mem[idx] >> (8 * o);
    end
    q.push_back(it);
    @(negedge clk);
    check("req_ack", 32'(req_ack), 32'd1);
    check("mem_ren", 32'(mem_ren), 32'(!c && !e));
    check("mem_wen", 32'(mem_wen), 32'(c && !e));
    if (!e) check("mem_addr", 32'(mem_addr), 32'(idx));
    if (!e && c) begin
      check("mem_be", 32'(mem_be), 32'(be));
      check("mem_wdata", mem_wdata, wd);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    check("idle_ren", 32'(mem_ren), 32'd0);
    check("idle_wen", 32'(mem_wen), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!done) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        mit = q.pop_front();
        check("resp", 32'(resp), 32'(mit.resp));
        check("rdata", rdata, mit.rdata);
      end else begin
        check("idle_resp", 32'(resp), 32'd0);
        if (rst) check("rst_rdata", rdata, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;

    // Reset with a live request: nothing may reach the memory.
    rst = 1'b1; req = 1'b1; cmd = 1'b0; width = 2'b10; addr = 32'h0;
    @(negedge clk);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_ren", 32'(mem_ren), 32'd0);
    cmd = 1'b1;
    @(negedge clk);
    check("rst_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;

    for (int i = 0; i < 16; i++) drive(1'b1, 2'b10, 32'(i * 4), 32'h0);
    idle();

    drive(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    drive(1'b1, 2'b00, 32'h13, 32'h000000A5);
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    drive(1'b1, 2'b10, 32'h20, 32'h12345678);
    drive(1'b0, 2'b01, 32'h22, 32'h0);
    idle();

    drive(1'b0, 2'b10, 32'h06, 32'h0);
    drive(1'b1, 2'b10, SIZE, 32'h11111111);
    drive(1'b0, 2'b11, 32'h08, 32'h0);
    drive(1'b0, 2'b01, 32'h01, 32'h0);
    drive(1'b1, 2'b01, SIZE - 2, 32'h2222);
    idle();

    drive(1'b1, 2'b10, 32'h0, 32'hA0A0A0A0);
    drive(1'b1, 2'b10, 32'h4, 32'hB1B1B1B1);
    drive(1'b1, 2'b10, 32'h8, 32'hC2C2C2C2);
    drive(1'b0, 2'b10, 32'h0, 32'h0);
    drive(1'b0, 2'b10, 32'h4, 32'h0);
    drive(1'b0, 2'b10, 32'h8, 32'h0);
    idle();

    // Reset lands the cycle after an accepted read; its response must vanish.
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1; cmd = 1'b0; width = 2'b10; addr = 32'h4;
    q.delete();
    @(negedge clk);
    check("mid_rst_ack", 32'(req_ack), 32'd0);
    check("mid_rst_ren", 32'(mem_ren), 32'd0);
    check("mid_rst_resp", 32'(resp), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    drive(1'b0, 2'b00, 32'h13, 32'h0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? SIZE + $urandom_range(0, 63) : 32'($urandom_range(0, 63));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end

    repeat (LAT + 2) idle();
    done = 1'b1;
    check("drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
